// File: rtl/sd_blk_tx_ctrl.sv
// Purpose: sequences an external byte->bit shifter to send one SD-style data block
//          on DAT0: start bit, data MSB first, CRC16 (0x1021) MSB first, end bit.
// Latency: first frame bit (start) on sd_dat two cycles after the first byte is accepted;
//          bytes stream gaplessly at one bit per cycle.
// Backpressure: in_ready is raised only when a byte is needed and held until in_valid.
//          A late byte leaves a gap on the line (bit_valid=0). With SD_TX_UNDERRUN_ABORT_EN
//          defined, a late byte after the first one aborts the frame and pulses err.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse in IDLE begins a block (ignored while busy)
//   busy, done      frame in progress / one-cycle pulse after the end bit
//   in_data/in_valid/in_ready   byte stream from the block buffer
//   ser_load, ser_enable, ser_data, ser_bit   shifter control / shifter MSB
//   sd_dat, bit_valid           serial line (idle high) and frame-bit qualifier
//   crc_out         CRC of the last block, latched when the CRC bits start
//   err             (only with SD_TX_UNDERRUN_ABORT_EN) underrun abort pulse

module sd_blk_tx_ctrl #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_load,
  output logic         ser_enable,
  output logic [7:0]   ser_data,
  input  logic         ser_bit,
  output logic         sd_dat,
  output logic         bit_valid,
  output logic [15:0]  crc_out
`ifdef SD_TX_UNDERRUN_ABORT_EN
  ,
  output logic         err
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_ENDB  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  byte_cnt;   // bytes accepted so far in this block
  logic [3:0]        dcnt;       // data bits still to appear on ser_bit for the loaded byte
  logic [3:0]        crc_cnt;    // CRC bits already placed on the line minus one
  logic              ld_q;       // shifter is capturing ser_data at the end of this cycle
  logic              tail;       // line is showing the final data bit of the block
  logic [15:0]       crc;
  logic [15:0]       crc_nx;
  logic              fb;
  logic              accept;
  logic              last_byte;

  assign in_ready  = (state == S_FETCH);
  assign accept    = in_ready & in_valid;
  assign ser_load  = accept;
  assign busy      = (state != S_IDLE);
  assign last_byte = (byte_cnt == LAST_CNT);

  // Shifter runs from acceptance until its last bit leaves; while a non-first byte is
  // late it keeps shifting (zeros), which is harmless since those bits are not driven.
  assign ser_enable = accept | ld_q | (dcnt != 4'd0) |
                      (in_ready & (byte_cnt != {CNT_W{1'b0}}));

  assign fb     = ser_bit ^ crc[15];
  assign crc_nx = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);

`ifdef SD_TX_UNDERRUN_ABORT_EN
  logic underrun;
  // Waiting for the very first byte is allowed; any later wait is an underrun.
  assign underrun = in_ready & ~in_valid & (byte_cnt != {CNT_W{1'b0}});
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      dcnt      <= 4'd0;
      crc_cnt   <= 4'd0;
      ld_q      <= 1'b0;
      tail      <= 1'b0;
      crc       <= 16'h0000;
      crc_out   <= 16'h0000;
      ser_data  <= 8'h00;
      sd_dat    <= 1'b1;
      bit_valid <= 1'b0;
      done      <= 1'b0;
`ifdef SD_TX_UNDERRUN_ABORT_EN
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SD_TX_UNDERRUN_ABORT_EN
      err  <= 1'b0;
`endif
      ld_q <= ser_load;

      case (state)
        S_IDLE: begin
          sd_dat    <= 1'b1;
          bit_valid <= 1'b0;
          if (start) begin
            crc      <= 16'h0000;
            byte_cnt <= '0;
            dcnt     <= 4'd0;
            crc_cnt  <= 4'd0;
            tail     <= 1'b0;
            state    <= S_FETCH;
          end
        end

        S_FETCH, S_DATA: begin
          // Byte handshake; the next byte is requested so its acceptance lands
          // eight cycles after the previous one, keeping the bit stream gapless.
          if (accept) begin
            ser_data <= in_data;
            byte_cnt <= byte_cnt + ONE_CNT;
            state    <= S_DATA;
          end else if (state == S_DATA && dcnt == 4'd3 && !last_byte) begin
            state <= S_FETCH;
          end

          if (ld_q)
            dcnt <= 4'd8;
          else if (dcnt != 4'd0)
            dcnt <= dcnt - 4'd1;

          // Line register: data bits lag ser_bit by one cycle and feed the CRC.
          if (tail) begin
            tail      <= 1'b0;
            crc_out   <= crc;
            sd_dat    <= crc[15];
            bit_valid <= 1'b1;
            crc       <= {crc[14:0], 1'b0};
            crc_cnt   <= 4'd0;
            state     <= S_CRC;
          end else if (dcnt != 4'd0) begin
            sd_dat    <= ser_bit;
            bit_valid <= 1'b1;
            crc       <= crc_nx;
            // ld_q here means another byte is already queued behind this one.
            tail      <= (dcnt == 4'd1) && last_byte && !ld_q;
          end else if (ld_q && byte_cnt == ONE_CNT) begin
            sd_dat    <= 1'b0;  // start bit, one cycle ahead of data bit 7
            bit_valid <= 1'b1;
          end else begin
            bit_valid <= 1'b0;
          end

`ifdef SD_TX_UNDERRUN_ABORT_EN
          if (underrun) begin
            err       <= 1'b1;
            sd_dat    <= 1'b1;
            bit_valid <= 1'b0;
            dcnt      <= 4'd0;
            tail      <= 1'b0;
            state     <= S_IDLE;
          end
`endif
        end

        S_CRC: begin
          bit_valid <= 1'b1;
          if (crc_cnt == 4'd15) begin
            sd_dat <= 1'b1;     // end bit
            state  <= S_ENDB;
          end else begin
            sd_dat  <= crc[15];
            crc     <= {crc[14:0], 1'b0};
            crc_cnt <= crc_cnt + 4'd1;
          end
        end

        S_ENDB: begin
          sd_dat    <= 1'b1;
          bit_valid <= 1'b0;
          done      <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          sd_dat    <= 1'b1;
          bit_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_tx_ctrl.sv
// Bench for sd_blk_tx_ctrl with a 9-byte block, a behavioural shifter, and a
// frame-level reference model (expected bit list built from the byte list).

module tb_sd_blk_tx_ctrl;

  localparam int BB = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        busy, done, in_ready, ser_load, ser_enable, ser_bit, sd_dat, bit_valid;
  logic [7:0]  ser_data;
  logic [15:0] crc_out;
`ifdef SD_TX_UNDERRUN_ABORT_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  sd_blk_tx_ctrl #(.BLOCK_BYTES(BB), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_load(ser_load), .ser_enable(ser_enable), .ser_data(ser_data),
    .ser_bit(ser_bit), .sd_dat(sd_dat), .bit_valid(bit_valid), .crc_out(crc_out)
`ifdef SD_TX_UNDERRUN_ABORT_EN
    , .err(err)
`endif
  );

  // Shifter with a registered load: load seen in cycle t, byte captured at end of t+1.
  logic       sh_ld_q;
  logic [7:0] sh_reg;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_ld_q <= 1'b0;
      sh_reg  <= 8'h00;
    end else if (ser_enable) begin
      sh_ld_q <= ser_load;
      if (sh_ld_q) sh_reg <= ser_data;
      else         sh_reg <= {sh_reg[6:0], 1'b0};
    end
  end
  assign ser_bit = sh_reg[7];

  // Line monitor
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic got_q[$];
  int   stamp_q[$];
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic err_sd_dat, err_busy;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bit_valid === 1'b1) begin
        got_q.push_back(sd_dat);
        stamp_q.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;
`ifdef SD_TX_UNDERRUN_ABORT_EN
      if (err === 1'b1) begin
        err_cnt++;
        err_sd_dat = sd_dat;
        err_busy   = busy;
      end
`endif
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      busy,       0);
    chk({tag, "_done"},      done,       0);
    chk({tag, "_in_ready"},  in_ready,   0);
    chk({tag, "_ser_load"},  ser_load,   0);
    chk({tag, "_ser_en"},    ser_enable, 0);
    chk({tag, "_ser_data"},  ser_data,   0);
    chk({tag, "_sd_dat"},    sd_dat,     1);
    chk({tag, "_bit_valid"}, bit_valid,  0);
    chk({tag, "_crc_out"},   crc_out,    0);
  endtask

  // Stimulus tables and reference model
  logic [7:0]  blk[BB];
  int          dly[BB];
  logic        exp_q[$];
  logic [15:0] exp_crc;

  task automatic build_model();
    logic [15:0] c;
    logic        b;
    c = 16'h0000;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < BB; i++)
      for (int k = 7; k >= 0; k--) begin
        b = blk[i][k];
        exp_q.push_back(b);
        c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
      end
    exp_crc = c;
    for (int k = 15; k >= 0; k--) exp_q.push_back(c[k]);
    exp_q.push_back(1'b1);
  endtask

  // Runs one frame. abort_at>0 pulls reset at that loop cycle; repulse pulses start while busy.
  task automatic run_frame(input int abort_at, input bit repulse, input bit hold_valid);
    int idx, d, n, gap, span, dsum;
    got_q.delete();
    stamp_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    mon_en   = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", busy, 1);
    idx = 0; d = dly[0]; n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 3000) begin
      if (idx < BB && in_ready) begin
        if (d > 0) begin
          in_valid = 1'b0; in_data = 8'($urandom); d--;
        end else begin
          in_valid = 1'b1; in_data = blk[idx]; idx++;
          if (idx < BB) d = dly[idx];
        end
      end else if (hold_valid) begin
        in_valid = 1'b1; in_data = (idx < BB) ? blk[idx] : 8'h00;
      end else begin
        in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
      end
      start = repulse && busy && (n % 11 == 4);
      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mon_en = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    if (err_cnt != 0) return;
    chk("done_timeout", (n < 3000), 1);
    chk("done_count", done_cnt, 1);
    chk("busy_end", busy, 0);
    chk("bit_count", got_q.size(), exp_q.size());
    chk("crc_out", crc_out, exp_crc);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("frame_bit", got_q[i], exp_q[i]);
    if (got_q.size() == exp_q.size()) begin
      dsum = 0;
      for (int i = 1; i < BB; i++) begin
        gap = stamp_q[8*i+1] - stamp_q[8*i] - 1;
        chk("byte_gap", gap, dly[i]);
        dsum += dly[i];
      end
      span = stamp_q[got_q.size()-1] - stamp_q[0] + 1;
      chk("frame_span", span, got_q.size() + dsum);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // "123456789", in_valid held high: 90 contiguous bits, CRC 0x31C3
    for (int i = 0; i < BB; i++) begin blk[i] = 8'(8'h31 + i); dly[i] = 0; end
    build_model();
    run_frame(0, 1'b0, 1'b1);
    chk("check_value_crc", crc_out, 16'h31C3);
    chk("check_value_len", got_q.size(), 8*BB + 18);

    // All zero bytes: zero CRC, only the end bit is high
    for (int i = 0; i < BB; i++) begin blk[i] = 8'h00; dly[i] = 0; end
    build_model();
    run_frame(0, 1'b0, 1'b0);
    chk("zero_crc", crc_out, 16'h0000);

`ifdef SD_TX_UNDERRUN_ABORT_EN
    // Underrun at the third byte request aborts the frame
    for (int i = 0; i < BB; i++) begin blk[i] = 8'($urandom); dly[i] = 0; end
    dly[0] = 3;
    dly[2] = 4;
    build_model();
    run_frame(0, 1'b0, 1'b0);
    chk("abort_err_count", err_cnt, 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_sd_dat", err_sd_dat, 1);
    chk("abort_busy", err_busy, 0);
`else
    // Random bytes, first-byte wait, 5-cycle underrun at second request, random later gaps
    for (int i = 0; i < BB; i++) begin blk[i] = 8'($urandom); dly[i] = $urandom_range(0, 3); end
    dly[0] = 3;
    dly[1] = 5;
    build_model();
    run_frame(0, 1'b0, 1'b0);
`endif

    // Reset mid-DATA, then a full correct frame
    for (int i = 0; i < BB; i++) begin blk[i] = 8'($urandom); dly[i] = 0; end
    build_model();
    run_frame(30, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_frame(0, 1'b0, 1'b0);

    // start re-pulsed while busy: exactly one frame and one done
    for (int i = 0; i < BB; i++) begin blk[i] = 8'($urandom); dly[i] = 0; end
    build_model();
    run_frame(0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
